user_req_sched: RTL and testbench

Round-robin scheduler that shares one descriptor-bypass request channel (the rd_req_user or wr_req_user path of a user region) among N_REQ requesters inside user logic. It accepts whole transfer requests, splits each into chunks that never cross a MAX_XFER-aligned boundary, and issues them on a single master channel. The number of in-flight chunks is limited by a completion-credit counter. One instance is used per direction (read, write).

---
 rtl/user_req_sched_pkg.sv | 17 +
 rtl/user_req_sched_rr_arbiter.sv | 44 ++++
 rtl/user_req_sched.sv | 148 ++++++++++++++
 tb/tb_user_req_sched.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_req_sched_pkg.sv
// -----------------------------------------------------------------------------
// user_req_sched_pkg
// Shared definitions for the user-region request scheduler: default address and
// length widths, and the scheduler FSM state encoding.
// -----------------------------------------------------------------------------
package user_req_sched_pkg;

  localparam int DEF_VADDR_BITS = 48;
  localparam int DEF_LEN_BITS   = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ISSUE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/user_req_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. Searches the request vector starting
// at ptr+1 (mod N) and returns the first set requester.
// Ports:
//   req        in  N          request vector
//   ptr        in  $clog2(N)  index of the most recently served requester
//   gnt_onehot out N          one-hot grant (all zero when nothing requested)
//   gnt_idx    out $clog2(N)  grant index (0 when nothing requested)
//   gnt_any    out 1          at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);

  localparam int IW = $clog2(N);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    return IW'((int'(base) + off) % N);
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    gnt_idx = '0;
    gnt_any = 1'b0;
    // Walk from the farthest candidate to the nearest; the last hit (closest
    // to ptr+1) overwrites earlier ones, so no early exit is needed.
    for (int off = N; off >= 1; off--) begin
      if (req[wrap_idx(ptr, off)]) begin
        gnt_any = 1'b1;
        gnt_idx = wrap_idx(ptr, off);
      end
    end
    gnt_onehot = gnt_any ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/user_req_sched.sv
// -----------------------------------------------------------------------------
// user_req_sched
// Round-robin scheduler sharing one descriptor-bypass request channel among
// N_REQ requesters. Each accepted request is split into chunks that never cross
// a MAX_XFER-aligned boundary; in-flight chunks are limited by a credit counter.
// Ports:
//   aclk, aresetn  clock, asynchronous active-low reset
//   s_valid/s_ready/s_vaddr/s_len  per-requester request (fields packed i*W)
//   m_valid/m_ready/m_vaddr/m_len/m_id/m_last  chunk issue channel
//   cpl_valid    one pulse per completed chunk
//   outstanding  issued-but-uncompleted chunk count
//   busy         FSM not idle
//   err_cpl      sticky: completion seen with nothing outstanding
// -----------------------------------------------------------------------------
module user_req_sched
  import user_req_sched_pkg::*;
#(
  parameter  int N_REQ         = 4,
  parameter  int MAX_XFER      = 4096,
  parameter  int N_OUTSTANDING = 8,
  parameter  int VADDR_BITS    = DEF_VADDR_BITS,
  parameter  int LEN_BITS      = DEF_LEN_BITS,
  localparam int ID_BITS       = $clog2(N_REQ),
  localparam int CNT_BITS      = $clog2(N_OUTSTANDING + 1)
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [N_REQ-1:0]            s_valid,
  output logic [N_REQ-1:0]            s_ready,
  input  logic [N_REQ*VADDR_BITS-1:0] s_vaddr,
  input  logic [N_REQ*LEN_BITS-1:0]   s_len,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [VADDR_BITS-1:0]       m_vaddr,
  output logic [LEN_BITS-1:0]         m_len,
  output logic [ID_BITS-1:0]          m_id,
  output logic                        m_last,
  input  logic                        cpl_valid,
  output logic [CNT_BITS-1:0]         outstanding,
  output logic                        busy,
  output logic                        err_cpl
);

  localparam int                   OFF_BITS   = $clog2(MAX_XFER);
  localparam logic [LEN_BITS-1:0]  MAX_LEN    = LEN_BITS'(MAX_XFER);
  localparam logic [CNT_BITS-1:0]  CREDIT_MAX = CNT_BITS'(N_OUTSTANDING);

  sched_state_t              state;
  logic [ID_BITS-1:0]        gnt;
  logic [ID_BITS-1:0]        ptr;
  logic [VADDR_BITS-1:0]     addr_q;
  logic [LEN_BITS-1:0]       rem_q;

  logic [N_REQ-1:0]          arb_onehot;
  logic [ID_BITS-1:0]        arb_idx;
  logic                      arb_any;

  logic [VADDR_BITS-1:0]     req_vaddr [N_REQ];
  logic [LEN_BITS-1:0]       req_len   [N_REQ];

  logic [LEN_BITS-1:0]       room;
  logic [LEN_BITS-1:0]       clen;
  logic                      in_issue;
  logic                      hs;
  logic                      dec;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_vaddr[g] = s_vaddr[g*VADDR_BITS +: VADDR_BITS];
    assign req_len[g]   = s_len[g*LEN_BITS +: LEN_BITS];
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req        (s_valid),
    .ptr        (ptr),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .gnt_any    (arb_any)
  );

  // Bytes left before the next MAX_XFER boundary; a chunk never crosses it.
  assign room     = MAX_LEN - LEN_BITS'(addr_q[OFF_BITS-1:0]);
  assign clen     = (rem_q < room) ? rem_q : room;
  assign in_issue = (state == ISSUE);

  assign m_valid  = in_issue && (outstanding < CREDIT_MAX);
  assign m_vaddr  = addr_q;
  assign m_len    = clen;
  assign m_id     = gnt;
  // Gated by state so the idle value (rem_q == clen == 0) does not read as last.
  assign m_last   = in_issue && (rem_q == clen);
  assign busy     = (state != IDLE);

  assign hs       = m_valid && m_ready;
  assign dec      = cpl_valid && (outstanding != '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!aresetn) begin
      state   <= IDLE;
      gnt     <= '0;
      ptr     <= ID_BITS'(N_REQ - 1);
      addr_q  <= '0;
      rem_q   <= '0;
      s_ready <= '0;
    end else begin
      s_ready <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            gnt     <= arb_idx;
            s_ready <= arb_onehot;
            state   <= GRANT;
          end
        end
        GRANT: begin
          addr_q <= req_vaddr[gnt];
          rem_q  <= req_len[gnt];
          ptr    <= gnt;
          state  <= (req_len[gnt] == '0) ? IDLE : ISSUE;
        end
        ISSUE: begin
          if (hs) begin
            addr_q <= addr_q + VADDR_BITS'(clen);
            rem_q  <= rem_q - clen;
            if (m_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      outstanding <= '0;
      err_cpl     <= 1'b0;
    end else begin
      case ({hs, dec})
        2'b10:   outstanding <= outstanding + CNT_BITS'(1);
        2'b01:   outstanding <= outstanding - CNT_BITS'(1);
        default: outstanding <= outstanding;
      endcase
      if (cpl_valid && (outstanding == '0)) err_cpl <= 1'b1;
    end
  end

endmodule

// File: tb/tb_user_req_sched.sv
// -----------------------------------------------------------------------------
// tb_user_req_sched
// Self-checking bench. Requests are queued per requester; a reference model
// derives the grant order (round robin over non-empty requester queues) and the
// chunk list (boundary-split arithmetic) and checks them against the DUT, along
// with a credit count, sticky error flag and hold-while-stalled behaviour.
// -----------------------------------------------------------------------------
module tb_user_req_sched;

  localparam int N_REQ    = 4;
  localparam int MAX_XFER = 4096;
  localparam int N_OUT    = 8;
  localparam int VB       = 48;
  localparam int LB       = 28;
  localparam int IDB      = $clog2(N_REQ);
  localparam int CB       = $clog2(N_OUT + 1);

  typedef struct {
    logic [VB-1:0] vaddr;
    longint        len;
    int            id;
  } req_t;

  typedef struct {
    logic [VB-1:0] vaddr;
    longint        len;
    int            id;
    bit            last;
  } chunk_t;

  logic                  aclk = 1'b0;
  logic                  aresetn = 1'b0;
  logic [N_REQ-1:0]      s_valid;
  logic [N_REQ-1:0]      s_ready;
  logic [N_REQ*VB-1:0]   s_vaddr;
  logic [N_REQ*LB-1:0]   s_len;
  logic                  m_valid;
  logic                  m_ready;
  logic [VB-1:0]         m_vaddr;
  logic [LB-1:0]         m_len;
  logic [IDB-1:0]        m_id;
  logic                  m_last;
  logic                  cpl_valid;
  logic [CB-1:0]         outstanding;
  logic                  busy;
  logic                  err_cpl;

  always #5 aclk = ~aclk;

  user_req_sched #(
    .N_REQ         (N_REQ),
    .MAX_XFER      (MAX_XFER),
    .N_OUTSTANDING (N_OUT),
    .VADDR_BITS    (VB),
    .LEN_BITS      (LB)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_vaddr     (s_vaddr),
    .s_len       (s_len),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_vaddr     (m_vaddr),
    .m_len       (m_len),
    .m_id        (m_id),
    .m_last      (m_last),
    .cpl_valid   (cpl_valid),
    .outstanding (outstanding),
    .busy        (busy),
    .err_cpl     (err_cpl)
  );

  int     n_vec = 0;
  int     n_err = 0;
  int     n_hs  = 0;

  req_t   pend[$];
  int     exp_gnt[$];
  int     obs_gnt[$];
  chunk_t exp_chk[$];
  chunk_t obs_chk[$];

  int     model_cnt = 0;
  bit     model_err = 0;
  int     model_ptr = N_REQ - 1;

  bit     hold_prev = 0;
  chunk_t held;
  int     rdy_pct = 100;
  bit     cpl_en  = 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add(input int id, input logic [VB-1:0] va, input longint len);
    req_t r;
    r.id = id; r.vaddr = va; r.len = len;
    pend.push_back(r);
  endtask

  // Split one request into boundary-respecting chunks.
  task automatic expect_request(input req_t r);
    logic [VB-1:0] a;
    longint rem, room, c;
    chunk_t ch;
    a = r.vaddr;
    rem = r.len;
    exp_gnt.push_back(r.id);
    while (rem > 0) begin
      room = MAX_XFER - longint'(a % MAX_XFER);
      c = (rem < room) ? rem : room;
      ch.vaddr = a; ch.len = c; ch.id = r.id; ch.last = (rem == c);
      exp_chk.push_back(ch);
      a = a + VB'(c);
      rem = rem - c;
    end
  endtask

  // Round robin over requesters that still have queued requests.
  task automatic plan();
    req_t tmp[$];
    bit found;
    int c;
    tmp = pend;
    while (tmp.size() > 0) begin
      found = 0;
      for (int off = 1; off <= N_REQ; off++) begin
        c = (model_ptr + off) % N_REQ;
        for (int k = 0; k < tmp.size(); k++) begin
          if (!found && tmp[k].id == c) begin
            expect_request(tmp[k]);
            tmp.delete(k);
            model_ptr = c;
            found = 1;
          end
        end
      end
    end
  endtask

  task automatic drive_requests();
    bit found;
    s_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      found = 0;
      for (int k = 0; k < pend.size(); k++) begin
        if (!found && pend[k].id == i) begin
          found = 1;
          s_valid[i] = 1'b1;
          s_vaddr[i*VB +: VB] = pend[k].vaddr;
          s_len[i*LB +: LB] = LB'(pend[k].len);
        end
      end
    end
  endtask

  task automatic step();
    int gid;
    bit granted;
    bit done;
    int nxt;
    chunk_t ch, e;
    granted = 0;
    gid = 0;
    @(negedge aclk);
    check("outstanding", outstanding, model_cnt);
    check("err_cpl", err_cpl, model_err);
    if (model_cnt >= N_OUT) check("credit_block", m_valid, 0);
    if (hold_prev) begin
      check("hold_valid", m_valid, 1);
      check("hold_vaddr", m_vaddr, held.vaddr);
      check("hold_len", m_len, held.len);
      check("hold_id", m_id, held.id);
      check("hold_last", m_last, held.last);
    end
    hold_prev = m_valid && !m_ready;
    held.vaddr = m_vaddr; held.len = m_len; held.id = int'(m_id); held.last = m_last;
    if (s_ready != '0) begin
      check("s_ready_onehot", $countones(s_ready), 1);
      for (int i = 0; i < N_REQ; i++) if (s_ready[i]) gid = i;
      granted = 1;
      obs_gnt.push_back(gid);
      if (exp_gnt.size() == 0) check("gnt_extra", s_ready, 0);
      else check("gnt_order", gid, exp_gnt.pop_front());
    end
    if (m_valid && m_ready) begin
      n_hs++;
      ch.vaddr = m_vaddr; ch.len = m_len; ch.id = int'(m_id); ch.last = m_last;
      obs_chk.push_back(ch);
      if (exp_chk.size() == 0) check("chunk_extra", m_valid, 0);
      else begin
        e = exp_chk.pop_front();
        check("chunk_vaddr", ch.vaddr, e.vaddr);
        check("chunk_len", ch.len, e.len);
        check("chunk_id", ch.id, e.id);
        check("chunk_last", ch.last, e.last);
      end
    end
    nxt = model_cnt + ((m_valid && m_ready) ? 1 : 0) - ((cpl_valid && model_cnt > 0) ? 1 : 0);
    if (cpl_valid && model_cnt == 0) model_err = 1;
    model_cnt = nxt;
    @(posedge aclk);
    #1;
    if (granted) begin
      done = 0;
      for (int k = 0; k < pend.size(); k++) begin
        if (!done && pend[k].id == gid) begin
          pend.delete(k);
          done = 1;
        end
      end
    end
    drive_requests();
    m_ready = ($urandom_range(99) < rdy_pct);
    cpl_valid = cpl_en && (model_cnt > 0) && ($urandom_range(99) < 40);
  endtask

  task automatic start();
    plan();
    drive_requests();
  endtask

  task automatic run(input int max_cycles);
    int n;
    n = 0;
    while ((pend.size() > 0 || exp_gnt.size() > 0 || exp_chk.size() > 0 || busy) && n < max_cycles) begin
      step();
      n++;
    end
    check("run_drained", exp_gnt.size() + exp_chk.size() + pend.size(), 0);
    check("run_idle", busy, 0);
  endtask

  task automatic drain_credit();
    int n;
    n = 0;
    cpl_en = 1;
    while (model_cnt > 0 && n < 300) begin
      step();
      n++;
    end
    check("drain_outstanding", outstanding, 0);
  endtask

  task automatic clear_obs();
    obs_gnt.delete();
    obs_chk.delete();
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_vaddr", m_vaddr, 0);
    check("rst_m_len", m_len, 0);
    check("rst_m_id", m_id, 0);
    check("rst_m_last", m_last, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_busy", busy, 0);
    check("rst_err_cpl", err_cpl, 0);
    pend.delete();
    exp_gnt.delete();
    exp_chk.delete();
    model_cnt = 0;
    model_err = 0;
    model_ptr = N_REQ - 1;
    hold_prev = 0;
    s_valid = '0;
    m_ready = 1'b0;
    cpl_valid = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int n, nreq, base_hs, base_g;
    logic [VB-1:0] va;
    longint ln;

    s_valid = '0; s_vaddr = '0; s_len = '0;
    m_ready = 1'b0; cpl_valid = 1'b0;
    apply_reset();

    // Aligned multi-chunk request.
    rdy_pct = 100; cpl_en = 1;
    clear_obs();
    add(0, 48'h1000, 'h2800);
    start();
    run(200);
    check("t1_nchunks", obs_chk.size(), 3);
    if (obs_chk.size() == 3) begin
      check("t1_c0_vaddr", obs_chk[0].vaddr, 'h1000);
      check("t1_c0_len", obs_chk[0].len, 'h1000);
      check("t1_c0_last", obs_chk[0].last, 0);
      check("t1_c1_vaddr", obs_chk[1].vaddr, 'h2000);
      check("t1_c2_vaddr", obs_chk[2].vaddr, 'h3000);
      check("t1_c2_len", obs_chk[2].len, 'h800);
      check("t1_c2_last", obs_chk[2].last, 1);
      check("t1_c2_id", obs_chk[2].id, 0);
    end

    // Unaligned request straddling a boundary.
    clear_obs();
    add(0, 48'h0F00, 'h300);
    start();
    run(200);
    check("t2_nchunks", obs_chk.size(), 2);
    if (obs_chk.size() == 2) begin
      check("t2_c0_len", obs_chk[0].len, 'h100);
      check("t2_c1_vaddr", obs_chk[1].vaddr, 'h1000);
      check("t2_c1_len", obs_chk[1].len, 'h200);
      check("t2_c1_last", obs_chk[1].last, 1);
    end

    // All requesters busy from reset: strict 0,1,2,3 rotation.
    apply_reset();
    clear_obs();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N_REQ; i++)
        add(i, VB'(i * 'h10000 + r * 'h100), 'h100);
    start();
    run(400);
    check("t3_ngrants", obs_gnt.size(), 12);
    if (obs_gnt.size() >= 8)
      for (int k = 0; k < 8; k++) check("t3_rr_order", obs_gnt[k], k % N_REQ);

    // Credit exhaustion and single-credit release.
    drain_credit();
    cpl_en = 0;
    rdy_pct = 100;
    add(0, 48'h0, 'h10000);
    start();
    base_hs = n_hs;
    repeat (20) step();
    check("t4_hs_at_limit", n_hs - base_hs, N_OUT);
    check("t4_mvalid_blocked", m_valid, 0);
    check("t4_outstanding_full", outstanding, N_OUT);
    cpl_valid = 1'b1;
    repeat (4) step();
    check("t4_hs_after_cpl", n_hs - base_hs, N_OUT + 1);
    check("t4_mvalid_reblocked", m_valid, 0);
    cpl_en = 1;
    run(600);

    // Zero-length request, then completion with nothing outstanding.
    drain_credit();
    base_g = obs_gnt.size();
    base_hs = n_hs;
    add(2, 48'h1234, 0);
    start();
    run(50);
    check("t5_len0_grant", obs_gnt.size() - base_g, 1);
    check("t5_len0_no_chunk", n_hs - base_hs, 0);
    cpl_en = 0;
    cpl_valid = 1'b1;
    step();
    step();
    check("t5_err_set", err_cpl, 1);
    repeat (5) step();
    check("t5_err_sticky", err_cpl, 1);

    // Randomized traffic with backpressure, completions and address wrap.
    cpl_en = 1;
    rdy_pct = 70;
    for (int round = 0; round < 4; round++) begin
      nreq = $urandom_range(4, 10);
      for (int k = 0; k < nreq; k++) begin
        if ($urandom_range(3) == 0) va = 48'hFFFF_FFFF_E000 + VB'($urandom_range(0, 'h1FFF));
        else va = VB'({$urandom(), $urandom()});
        if ($urandom_range(5) == 0) ln = 0;
        else ln = longint'($urandom_range(1, 'h2400));
        add($urandom_range(0, N_REQ - 1), va, ln);
      end
      start();
      run(3000);
    end

    // Asynchronous reset while a chunk is being offered.
    drain_credit();
    cpl_en = 0;
    rdy_pct = 0;
    add(0, 48'h5000, 'h10000);
    start();
    n = 0;
    while (!m_valid && n < 10) begin
      step();
      n++;
    end
    check("t7_mvalid_before_rst", m_valid, 1);
    apply_reset();
    rdy_pct = 100;
    cpl_en = 1;
    clear_obs();
    add(2, 48'h8000, 'h100);
    add(0, 48'h9000, 'h100);
    start();
    run(200);
    check("t7_post_rst_ngrants", obs_gnt.size(), 2);
    if (obs_gnt.size() == 2) begin
      check("t7_first_gnt", obs_gnt[0], 0);
      check("t7_second_gnt", obs_gnt[1], 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
